dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// Two-requester arbiter in front of a single-ported data memory. Each access
// takes a fixed three-cycle trip through IDLE -> ACCESS -> RESP: the winner's
// request is latched in IDLE, the memory is strobed in ACCESS (only when the
// address is a word-aligned location inside the memory), and the winner gets a
// one-cycle ack (with err for a rejected address) in RESP. Simultaneous
// requests are resolved by a one-bit round-robin pointer.
//
// Parameters
//   MEM_BYTES      byte size of the data memory served
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous active-low reset
//   req0/req1      access request, held until ack
//   wr0/wr1        1 = write, 0 = read (valid while req is high)
//   addr0/addr1    byte address of a big-endian word
//   wdata0/wdata1  write data
//   ack0/ack1      one-cycle completion pulse
//   err0/err1      with ack: the address was rejected
//   rdata          read data, valid in the ack cycle
//   busy           high whenever the FSM is not IDLE
//   dm_cs/dm_wr/dm_rd  memory strobes, only ever high in ACCESS
//   Address/D_in   memory address / write data (latched request values)
//   D_Out          combinational memory read data
// -----------------------------------------------------------------------------
module dm_arbiter #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        dm_cs,
    output logic        dm_wr,
    output logic        dm_rd,
    output logic [31:0] Address,
    output logic [31:0] D_in,
    input  logic [31:0] D_Out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // Highest byte address at which a whole word still fits in the memory.
    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    logic [1:0]  state;
    logic        ptr;        // requester that wins a tie
    logic        winner_q;   // requester being served
    logic        wr_q;
    logic        valid_q;    // latched address check of the winner
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    // Selection of the winner among the current requests.
    logic        any_req;
    logic        sel;
    logic        sel_wr;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_valid;

    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        any_req   = req0 | req1;
        sel       = 1'b0;
        if (req0 && req1) begin
            sel = ptr;
        end else if (req1) begin
            sel = 1'b1;
        end
        sel_wr    = sel ? wr1    : wr0;
        sel_addr  = sel ? addr1  : addr0;
        sel_wdata = sel ? wdata1 : wdata0;
        // Checking the address while latching keeps the comparator off the
        // ACCESS-cycle path to the memory strobes.
        sel_valid = (sel_addr[1:0] == 2'b00) && (sel_addr <= LAST_WORD);
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the datapath registers are reset too, because Address,
            // D_in and rdata must read 0 in the cycle after reset.
            state    <= S_IDLE;
            ptr      <= 1'b0;
            winner_q <= 1'b0;
            wr_q     <= 1'b0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        winner_q <= sel;
                        wr_q     <= sel_wr;
                        valid_q  <= sel_valid;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Writes and rejected addresses return 0 so a stale read
                    // value never leaks into another transaction's ack.
                    rdata_q <= (valid_q && !wr_q) ? D_Out : 32'd0;
                    state   <= S_RESP;
                end
                S_RESP: begin
                    ptr   <= ~winner_q;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    logic in_access;
    logic in_resp;

    assign in_access = (state == S_ACCESS);
    assign in_resp   = (state == S_RESP);

    // A rejected address never reaches the memory.
    assign dm_cs   = in_access && valid_q;
    assign dm_wr   = dm_cs && wr_q;
    assign dm_rd   = dm_cs && !wr_q;
    assign Address = addr_q;
    assign D_in    = wdata_q;

    assign ack0  = in_resp && !winner_q;
    assign ack1  = in_resp &&  winner_q;
    assign err0  = ack0 && !valid_q;
    assign err1  = ack1 && !valid_q;
    assign rdata = rdata_q;
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
//
// Directed bench for dm_arbiter with a big-endian byte memory model on the
// memory port. Each transaction pushes its expected ack owner, err and rdata
// into a scoreboard queue; the entry is popped and compared when an ack shows.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

    localparam int MEM_BYTES = 4096;

    typedef struct {
        bit          id;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, wr0, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata;
    logic        busy, dm_cs, dm_wr, dm_rd;
    logic [31:0] Address, D_in, D_Out;

    logic [7:0]  mem [MEM_BYTES];
    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          cs_count = 0;

    dm_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .wr0    (wr0),
        .wr1    (wr1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .ack0   (ack0),
        .ack1   (ack1),
        .err0   (err0),
        .err1   (err1),
        .rdata  (rdata),
        .busy   (busy),
        .dm_cs  (dm_cs),
        .dm_wr  (dm_wr),
        .dm_rd  (dm_rd),
        .Address(Address),
        .D_in   (D_in),
        .D_Out  (D_Out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dm_cs) cs_count <= cs_count + 1;
        if (dm_cs && dm_wr && Address <= 32'(MEM_BYTES - 4)) begin
            mem[Address]      <= D_in[31:24];
            mem[Address + 1]  <= D_in[23:16];
            mem[Address + 2]  <= D_in[15:8];
            mem[Address + 3]  <= D_in[7:0];
        end
    end

    always_comb begin
        D_Out = 32'd0;
        if (Address <= 32'(MEM_BYTES - 4))
            D_Out = {mem[Address], mem[Address + 1], mem[Address + 2], mem[Address + 3]};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for any ack; got=0 when the bound expires.
    task automatic wait_ack(input int limit, output bit got);
        int n;
        n   = 0;
        got = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack0 || ack1) && n < limit);
        got = ack0 || ack1;
    endtask

    // Pops the scoreboard and compares against the ack now showing.
    task automatic score(input string tag);
        exp_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL %s.sb: observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".acks"}, {ack1, ack0}, e.id ? 2'b10 : 2'b01);
            check({tag, ".err"}, e.id ? err1 : err0, e.err);
            check({tag, ".err_other"}, e.id ? err0 : err1, 1'b0);
            check({tag, ".rdata"}, rdata, e.rdata);
        end
    endtask

    // One transaction from a single requester. With scramble set, the
    // requester's address and data change in the ACCESS cycle.
    task automatic txn(input string tag, input bit id, input bit wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit exp_err, input logic [31:0] exp_rdata,
                       input bit scramble);
        exp_t e;
        int   c0;
        bit   got;
        @(negedge clk);
        if (id) begin req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = d; end
        else    begin req0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = d; end
        e.id = id; e.err = exp_err; e.rdata = exp_rdata;
        sb.push_back(e);
        c0 = cyc;
        @(negedge clk);
        check({tag, ".busy"}, busy, 1'b1);
        check({tag, ".cs"}, dm_cs, !exp_err);
        check({tag, ".wr"}, dm_wr, !exp_err && wr);
        check({tag, ".rd"}, dm_rd, !exp_err && !wr);
        check({tag, ".addr"}, Address, a);
        if (scramble) begin
            if (id) begin addr1 = a ^ 32'h80; wdata1 = ~d; end
            else    begin addr0 = a ^ 32'h80; wdata0 = ~d; end
            #1;
            check({tag, ".addr_hold"}, Address, a);
            check({tag, ".din_hold"}, D_in, d);
        end
        wait_ack(4, got);
        check({tag, ".got_ack"}, got, 1'b1);
        check({tag, ".latency"}, cyc - c0, 2);
        score(tag);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check({tag, ".idle"}, {busy, ack1, ack0}, 3'b000);
    endtask

    initial begin
        int  cs0;
        int  last;
        bit  got;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
        reset = 1'b0;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst.ctl", {ack0, ack1, err0, err1, busy, dm_cs, dm_wr, dm_rd}, 8'h00);
        check("rst.addr", Address, 32'd0);
        check("rst.din", D_in, 32'd0);
        check("rst.rdata", rdata, 32'd0);
        reset = 1'b1;

        // Write then read back through requester 0.
        txn("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0);
        txn("rd10", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

        // Last word of memory, written by 0, read by 1.
        txn("wrffc", 1'b0, 1'b1, 32'hFFC, 32'h01020304, 1'b0, 32'd0, 1'b0);
        txn("rdffc", 1'b1, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'h01020304, 1'b0);

        // Rejected addresses: misaligned and just past the end.
        cs0 = cs_count;
        txn("rdffd", 1'b1, 1'b0, 32'hFFD, 32'h0, 1'b1, 32'd0, 1'b0);
        txn("rd1000", 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 32'd0, 1'b0);
        check("bad.no_cs", cs_count - cs0, 0);

        // Inputs changed mid-transaction must not disturb it.
        txn("wr40", 1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0, 32'd0, 1'b1);
        txn("rd40", 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h12345678, 1'b0);
        txn("rdc0", 1'b0, 1'b0, 32'hC0, 32'h0, 1'b0, 32'd0, 1'b0);

        // Reset during ACCESS of a write: write commits, no ack.
        @(negedge clk);
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hA5A5A5A5;
        @(negedge clk);
        check("rstacc.cs", {dm_cs, dm_wr}, 2'b11);
        reset = 1'b0;
        req0  = 1'b0;
        @(negedge clk);
        check("rstacc.ctl", {ack0, ack1, err0, err1, busy, dm_cs}, 6'h00);
        check("rstacc.addr", Address, 32'd0);
        check("rstacc.rdata", rdata, 32'd0);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rstacc.no_ack", {ack1, ack0}, 2'b00);
        end
        txn("rd20", 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0);

        // Both requesting from reset: strict alternation, 3 cycles apart.
        @(negedge clk);
        reset = 1'b0;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 32'hFFC;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.id    = k[0];
            e.err   = 1'b0;
            e.rdata = k[0] ? 32'h01020304 : 32'hDEADBEEF;
            sb.push_back(e);
        end
        @(negedge clk);
        reset = 1'b1;
        last  = cyc - 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(6, got);
            check("rr.got_ack", got, 1'b1);
            check("rr.spacing", cyc - last, 3);
            last = cyc;
            score("rr");
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        check("end.sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
